// File: rtl/rate_limiter_pkg.sv
// Shared pacing types and law for the egress rate limiter
// and its receive-side rate monitor.
package rate_limiter_pkg;

  localparam int CNT_W   = 24;
  localparam int SHIFT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_PKT = 2'd1,
    IN_GAP = 2'd2
  } state_t;

  // Required gap = v << sh, clamped to w bits. Worked at 64 bits
  // so any w up to 49 keeps the full unsaturated product.
  function automatic logic [63:0] sat_shl(
    input logic [63:0]        v,
    input logic [SHIFT_W-1:0] sh,
    input int unsigned        w
  );
    logic [63:0] wide;
    logic [63:0] lim;
    lim  = (64'd1 << w) - 64'd1;
    wide = v << sh;
    return (wide > lim) ? lim : wide;
  endfunction

endpackage

// File: rtl/rate_monitor_sat_counter.sv
// Saturating up-counter; clr restarts it (at 1 if inc is also set).
// Ports: clk, reset (async, low), clr, inc, q.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      q <= '0;
    else if (clr)
      q <= {{(WIDTH-1){1'b0}}, inc};
    else if (inc && !(&q))
      q <= q + WIDTH'(1);
  end

endmodule

// File: rtl/rate_monitor.sv
// Passive checker of packet length / idle gap against the pacing law.
// Ports: bus tap (in_*), enable, thruput_shift, clear, counters/snapshots.
module rate_monitor
  import rate_limiter_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  input  logic                  enable,
  input  logic [SHIFT_W-1:0]    thruput_shift,
  input  logic                  clear,
  output logic [31:0]           pkt_count,
  output logic [31:0]           word_count,
  output logic [15:0]           violation_count,
  output logic [CNT_WIDTH-1:0]  last_len,
  output logic [CNT_WIDTH-1:0]  last_gap,
  output logic                  violation
);

  state_t state, state_nx;

  logic prev0, act, eop, fail;
  logic len_inc, len_clr;
  logic gap_inc, gap_clr;
  logic done, done_one, check;
  logic [CNT_WIDTH-1:0] len, gap, required;
  logic [CNT_WIDTH-1:0] len_final, done_len;
  logic data_unused;

  assign data_unused = ^in_data;
  assign act = enable & ~clear;
  assign eop = in_wr & (|in_ctrl) & prev0;

  assign len_final = (&len) ? len
                   : len + CNT_WIDTH'(1);
  // done: multi-word packet ends; done_one: start word is also eop
  assign done_len  = done ? len_final
                   : CNT_WIDTH'(1);
  assign fail = check & (gap < required);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_len (
    .clk   (clk),
    .reset (reset),
    .clr   (clear | len_clr),
    .inc   (len_inc),
    .q     (len)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_gap (
    .clk   (clk),
    .reset (reset),
    .clr   (clear | gap_clr),
    .inc   (gap_inc),
    .q     (gap)
  );

  sat_counter #(.WIDTH(16)) u_viol (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (fail),
    .q     (violation_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else if (clear)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (act) begin
      unique case (state)
        IDLE:    if (in_wr && !eop) state_nx = IN_PKT;
        IN_PKT:  if (eop) state_nx = IN_GAP;
        IN_GAP:  if (in_wr && !eop) state_nx = IN_PKT;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    len_inc  = 1'b0;
    len_clr  = 1'b0;
    gap_inc  = 1'b0;
    gap_clr  = 1'b0;
    done     = 1'b0;
    done_one = 1'b0;
    check    = 1'b0;
    unique case (1'b1)
      act && state == IDLE: begin
        done_one = eop;
        len_clr  = in_wr & ~eop;
        len_inc  = in_wr & ~eop;
      end
      act && state == IN_PKT: begin
        len_inc = in_wr;
        done    = eop;
        gap_clr = eop;
      end
      act && state == IN_GAP: begin
        gap_inc  = ~in_wr;
        check    = in_wr;
        done_one = eop;
        gap_clr  = eop;
        len_clr  = in_wr & ~eop;
        len_inc  = in_wr & ~eop;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev0      <= 1'b0;
      pkt_count  <= '0;
      word_count <= '0;
      last_len   <= '0;
      last_gap   <= '0;
      required   <= '0;
      violation  <= 1'b0;
    end else if (clear) begin
      prev0      <= 1'b0;
      pkt_count  <= '0;
      word_count <= '0;
      last_len   <= '0;
      last_gap   <= '0;
      required   <= '0;
      violation  <= 1'b0;
    end else begin
      violation <= fail;
      if (enable && in_wr) begin
        prev0      <= ~|in_ctrl;
        word_count <= word_count + 32'd1;
      end
      if (done || done_one) begin
        last_len  <= done_len;
        pkt_count <= pkt_count + 32'd1;
        required  <= CNT_WIDTH'(sat_shl(
                       64'(done_len),
                       thruput_shift,
                       CNT_WIDTH));
      end
      if (check)
        last_gap <= gap;
    end
  end

endmodule
